// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: two-entry in-order writeback queue in front of a register file.
// Requests are buffered as {addr, imm, data} and drained one per cycle to the
// rf_* write port unless hold is asserted. Operand reads are checked against
// the queued, not-yet-written entries.
// Optional feature macro: WB_BYPASS_EN
//   defined   -> matching operands are forwarded from the youngest queued entry
//   undefined -> matching operands raise rd_hazard and read the register file
module reg_wb_ctrl #(
    parameter int W   = 8,
    parameter int D   = 3,
    parameter int RIM = 2**D - 1
) (
    input  logic         CLK,
    input  logic         reset_n,

    input  logic         wb_valid,
    output logic         wb_ready,
    input  logic [D-1:0] wb_addr,
    input  logic         wb_imm,
    input  logic [W-1:0] wb_data,
    input  logic         hold,

    output logic         rf_write_en,
    output logic         rf_write_imm,
    output logic [D-1:0] rf_waddr,
    output logic [W-1:0] rf_data_in,

    input  logic [D-1:0] rd_addrA,
    input  logic [D-1:0] rd_addrB,
    output logic [D-1:0] rf_raddrA,
    output logic [D-1:0] rf_raddrB,
    input  logic [W-1:0] rf_data_outA,
    input  logic [W-1:0] rf_data_outB,
    output logic [W-1:0] rd_dataA,
    output logic [W-1:0] rd_dataB,
    output logic         rd_hazard
);

    // Immediate writes land in this fixed register.
    localparam logic [D-1:0] RIM_ADDR = D'(RIM);

    // Slot 0 is always the head (oldest); slot 1 is only valid when full.
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic [D-1:0] addr_q [2];
    logic [D-1:0] addr_d [2];
    logic         imm_q  [2];
    logic         imm_d  [2];
    logic [W-1:0] data_q [2];
    logic [W-1:0] data_d [2];

    logic         valid0;
    logic         valid1;
    logic         do_push;
    logic         do_pop;
    logic         wr_slot;
    logic [D-1:0] eff_addr;

    logic         match_a0;
    logic         match_a1;
    logic         match_b0;
    logic         match_b1;
    logic         hit_a;
    logic         hit_b;

    assign valid0 = (count_q != 2'd0);
    assign valid1 = (count_q == 2'd2);

    // Reset forces the handshake and the write strobe low regardless of state.
    assign wb_ready    = reset_n && (count_q != 2'd2);
    assign rf_write_en = reset_n && valid0 && !hold;

    assign do_push  = wb_valid && wb_ready;
    assign do_pop   = rf_write_en;
    assign eff_addr = wb_imm ? RIM_ADDR : wb_addr;

    // A push lands after the last valid slot, counted after any same-cycle pop.
    assign wr_slot = do_pop ? valid1 : (count_q == 2'd1);

    // Write port shows the head entry only while it is actually being written.
    assign rf_write_imm = rf_write_en && imm_q[0];
    assign rf_waddr     = rf_write_en ? addr_q[0] : '0;
    assign rf_data_in   = rf_write_en ? data_q[0] : '0;

    // Read addresses pass straight through to the register file.
    assign rf_raddrA = rd_addrA;
    assign rf_raddrB = rd_addrB;

    // Operand comparisons against each valid queued entry.
    assign match_a0 = valid0 && (addr_q[0] == rd_addrA);
    assign match_a1 = valid1 && (addr_q[1] == rd_addrA);
    assign match_b0 = valid0 && (addr_q[0] == rd_addrB);
    assign match_b1 = valid1 && (addr_q[1] == rd_addrB);
    assign hit_a    = match_a0 || match_a1;
    assign hit_b    = match_b0 || match_b1;

`ifdef WB_BYPASS_EN
    // Forwarding: slot 1 is younger than slot 0, so it wins when both match.
    logic [W-1:0] fwd_a;
    logic [W-1:0] fwd_b;

    assign fwd_a     = match_a1 ? data_q[1] : data_q[0];
    assign fwd_b     = match_b1 ? data_q[1] : data_q[0];
    assign rd_dataA  = hit_a ? fwd_a : rf_data_outA;
    assign rd_dataB  = hit_b ? fwd_b : rf_data_outB;
    assign rd_hazard = 1'b0;
`else
    // No forwarding: decode must stall while a pending write matches.
    assign rd_dataA  = rf_data_outA;
    assign rd_dataB  = rf_data_outB;
    assign rd_hazard = hit_a || hit_b;
`endif

    // Next-state queue contents: pop shifts slot 1 down, then push fills a slot.
    always_comb begin
        count_d   = count_q;
        addr_d[0] = addr_q[0];
        addr_d[1] = addr_q[1];
        imm_d[0]  = imm_q[0];
        imm_d[1]  = imm_q[1];
        data_d[0] = data_q[0];
        data_d[1] = data_q[1];

        if (do_pop) begin
            addr_d[0] = addr_q[1];
            imm_d[0]  = imm_q[1];
            data_d[0] = data_q[1];
            addr_d[1] = '0;
            imm_d[1]  = 1'b0;
            data_d[1] = '0;
            count_d   = count_d - 2'd1;
        end

        if (do_push) begin
            addr_d[wr_slot] = eff_addr;
            imm_d[wr_slot]  = wb_imm;
            data_d[wr_slot] = wb_data;
            count_d         = count_d + 2'd1;
        end
    end

    // Queue state register; reset discards everything, including same-cycle traffic.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            count_q   <= 2'd0;
            addr_q[0] <= '0;
            addr_q[1] <= '0;
            imm_q[0]  <= 1'b0;
            imm_q[1]  <= 1'b0;
            data_q[0] <= '0;
            data_q[1] <= '0;
        end else begin
            count_q   <= count_d;
            addr_q[0] <= addr_d[0];
            addr_q[1] <= addr_d[1];
            imm_q[0]  <= imm_d[0];
            imm_q[1]  <= imm_d[1];
            data_q[0] <= data_d[0];
            data_q[1] <= data_d[1];
        end
    end

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// tb_reg_wb_ctrl: directed scenarios plus randomized traffic for reg_wb_ctrl,
// checked against a queue-based reference model of the writeback buffer.
// Honors WB_BYPASS_EN the same way as the design.
module tb_reg_wb_ctrl;

    localparam int W   = 8;
    localparam int D   = 3;
    localparam int RIM = 7;

    logic         CLK;
    logic         reset_n;
    logic         wb_valid;
    logic         wb_ready;
    logic [D-1:0] wb_addr;
    logic         wb_imm;
    logic [W-1:0] wb_data;
    logic         hold;
    logic         rf_write_en;
    logic         rf_write_imm;
    logic [D-1:0] rf_waddr;
    logic [W-1:0] rf_data_in;
    logic [D-1:0] rd_addrA;
    logic [D-1:0] rd_addrB;
    logic [D-1:0] rf_raddrA;
    logic [D-1:0] rf_raddrB;
    logic [W-1:0] rf_data_outA;
    logic [W-1:0] rf_data_outB;
    logic [W-1:0] rd_dataA;
    logic [W-1:0] rd_dataB;
    logic         rd_hazard;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [D-1:0] addr;
        logic         imm;
        logic [W-1:0] data;
    } entry_t;

    entry_t model_q[$];

    reg_wb_ctrl #(.W(W), .D(D), .RIM(RIM)) dut (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_imm       (wb_imm),
        .wb_data      (wb_data),
        .hold         (hold),
        .rf_write_en  (rf_write_en),
        .rf_write_imm (rf_write_imm),
        .rf_waddr     (rf_waddr),
        .rf_data_in   (rf_data_in),
        .rd_addrA     (rd_addrA),
        .rd_addrB     (rd_addrB),
        .rf_raddrA    (rf_raddrA),
        .rf_raddrB    (rf_raddrB),
        .rf_data_outA (rf_data_outA),
        .rf_data_outB (rf_data_outB),
        .rd_dataA     (rd_dataA),
        .rd_dataB     (rd_dataB),
        .rd_hazard    (rd_hazard)
    );

    // Free-running clock, 10 time-unit period.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic driveInputs(input logic rst_n, input logic valid, input logic imm,
                               input logic [D-1:0] addr, input logic [W-1:0] data,
                               input logic hld, input logic [D-1:0] ra, input logic [D-1:0] rb);
        reset_n      = rst_n;
        wb_valid     = valid;
        wb_imm       = imm;
        wb_addr      = addr;
        wb_data      = data;
        hold         = hld;
        rd_addrA     = ra;
        rd_addrB     = rb;
        rf_data_outA = W'($urandom_range(0, 255));
        rf_data_outB = W'($urandom_range(0, 255));
    endtask

    // Youngest queued entry whose address matches, if any.
    task automatic lookup(input logic [D-1:0] a, output logic hit, output logic [W-1:0] val);
        hit = 1'b0;
        val = '0;
        for (int i = model_q.size() - 1; i >= 0; i--) begin
            if (!hit && model_q[i].addr == a) begin
                hit = 1'b1;
                val = model_q[i].data;
            end
        end
    endtask

    task automatic checkModel();
        logic         exp_ready;
        logic         exp_wen;
        logic         hit_a;
        logic         hit_b;
        logic [W-1:0] val_a;
        logic [W-1:0] val_b;
        exp_ready = reset_n && (model_q.size() < 2);
        exp_wen   = reset_n && (model_q.size() > 0) && !hold;
        checkOutput("wb_ready", 32'(wb_ready), 32'(exp_ready));
        checkOutput("rf_write_en", 32'(rf_write_en), 32'(exp_wen));
        checkOutput("rf_write_imm", 32'(rf_write_imm), 32'(exp_wen && model_q[0].imm));
        checkOutput("rf_waddr", 32'(rf_waddr), exp_wen ? 32'(model_q[0].addr) : 32'd0);
        checkOutput("rf_data_in", 32'(rf_data_in), exp_wen ? 32'(model_q[0].data) : 32'd0);
        checkOutput("rf_raddrA", 32'(rf_raddrA), 32'(rd_addrA));
        checkOutput("rf_raddrB", 32'(rf_raddrB), 32'(rd_addrB));
        lookup(rd_addrA, hit_a, val_a);
        lookup(rd_addrB, hit_b, val_b);
`ifdef WB_BYPASS_EN
        checkOutput("rd_hazard", 32'(rd_hazard), 32'd0);
        checkOutput("rd_dataA", 32'(rd_dataA), hit_a ? 32'(val_a) : 32'(rf_data_outA));
        checkOutput("rd_dataB", 32'(rd_dataB), hit_b ? 32'(val_b) : 32'(rf_data_outB));
`else
        checkOutput("rd_hazard", 32'(rd_hazard), 32'(hit_a || hit_b));
        checkOutput("rd_dataA", 32'(rd_dataA), 32'(rf_data_outA));
        checkOutput("rd_dataB", 32'(rd_dataB), 32'(rf_data_outB));
`endif
    endtask

    // Advance one clock and apply the queue rules to the model using the driven inputs.
    task automatic tick();
        logic   push;
        logic   pop;
        entry_t e;
        @(posedge CLK);
        push = reset_n && wb_valid && (model_q.size() < 2);
        pop  = reset_n && (model_q.size() > 0) && !hold;
        if (!reset_n) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) begin
                e.addr = wb_imm ? D'(RIM) : wb_addr;
                e.imm  = wb_imm;
                e.data = wb_data;
                model_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic applyStimulus(input logic rst_n, input logic valid, input logic imm,
                                 input logic [D-1:0] addr, input logic [W-1:0] data,
                                 input logic hld, input logic [D-1:0] ra, input logic [D-1:0] rb);
        driveInputs(rst_n, valid, imm, addr, data, hld, ra, rb);
        #2;
        checkModel();
        tick();
    endtask

    initial begin
        driveInputs(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);
        tick();
        // Reset state
        driveInputs(1'b0, 1'b1, 1'b0, 3'd1, 8'hAA, 1'b0, 3'd1, 3'd2);
        #2;
        checkModel();
        checkOutput("reset_ready", 32'(wb_ready), 32'd0);
        checkOutput("reset_wen", 32'(rf_write_en), 32'd0);
        checkOutput("reset_hazard", 32'(rd_hazard), 32'd0);
        checkOutput("reset_rdA", 32'(rd_dataA), 32'(rf_data_outA));
        tick();

        // Single request, next-cycle write
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 8'h5A, 1'b0, 3'd0, 3'd1);
        driveInputs(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd1);
        #2;
        checkModel();
        checkOutput("single_wen", 32'(rf_write_en), 32'd1);
        checkOutput("single_waddr", 32'(rf_waddr), 32'd3);
        checkOutput("single_data", 32'(rf_data_in), 32'h5A);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 3'd3);

        // Fill under hold, then drain in order
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd1, 8'h11, 1'b1, 3'd0, 3'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd2, 8'h22, 1'b1, 3'd1, 3'd2);
        driveInputs(1'b1, 1'b1, 1'b0, 3'd5, 8'h99, 1'b1, 3'd0, 3'd0);
        #2;
        checkModel();
        checkOutput("full_ready", 32'(wb_ready), 32'd0);
        tick();
        driveInputs(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);
        #2;
        checkModel();
        checkOutput("drain1_waddr", 32'(rf_waddr), 32'd1);
        tick();
        driveInputs(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);
        #2;
        checkModel();
        checkOutput("drain2_waddr", 32'(rf_waddr), 32'd2);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);

        // Same address queued twice, youngest wins
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd4, 8'h10, 1'b1, 3'd0, 3'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd4, 8'h20, 1'b1, 3'd0, 3'd0);
        driveInputs(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd0);
        #2;
        checkModel();
`ifdef WB_BYPASS_EN
        checkOutput("dup_rdA", 32'(rd_dataA), 32'h20);
        checkOutput("dup_hazard", 32'(rd_hazard), 32'd0);
`else
        checkOutput("dup_hazard", 32'(rd_hazard), 32'd1);
        checkOutput("dup_rdA", 32'(rd_dataA), 32'(rf_data_outA));
`endif
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd4, 3'd4);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd4, 3'd4);

        // Immediate write targets RIM
        applyStimulus(1'b1, 1'b1, 1'b1, 3'd2, 8'h7F, 1'b1, 3'd0, 3'd0);
        driveInputs(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd2, 3'd7);
        #2;
        checkModel();
        checkOutput("imm_wimm", 32'(rf_write_imm), 32'd1);
        checkOutput("imm_waddr", 32'(rf_waddr), 32'd7);
`ifdef WB_BYPASS_EN
        checkOutput("imm_rdB", 32'(rd_dataB), 32'h7F);
`endif
        tick();

        // Enqueue and drain in the same cycle at count 1
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd5, 8'h33, 1'b1, 3'd0, 3'd0);
        driveInputs(1'b1, 1'b1, 1'b0, 3'd6, 8'h44, 1'b0, 3'd6, 3'd5);
        #2;
        checkModel();
        checkOutput("simul_waddr", 32'(rf_waddr), 32'd5);
        checkOutput("simul_ready", 32'(wb_ready), 32'd1);
        tick();
        driveInputs(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd6, 3'd0);
        #2;
        checkModel();
        checkOutput("simul_next_data", 32'(rf_data_in), 32'h44);
        tick();

        // Reset while full with a request pending
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd1, 8'hC1, 1'b1, 3'd0, 3'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'd2, 8'hC2, 1'b1, 3'd0, 3'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd3, 8'hC3, 1'b0, 3'd1, 3'd2);
        driveInputs(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 3'd2);
        #2;
        checkModel();
        checkOutput("post_reset_wen", 32'(rf_write_en), 32'd0);
        checkOutput("post_reset_ready", 32'(wb_ready), 32'd1);
        checkOutput("post_reset_hazard", 32'(rd_hazard), 32'd0);
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 49) != 0),
                          ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 4) == 0),
                          D'($urandom_range(0, 7)),
                          W'($urandom_range(0, 255)),
                          ($urandom_range(0, 2) == 0),
                          D'($urandom_range(0, 7)),
                          D'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_wb_ctrl.md
REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

Interface
REQ-001 Parameter W, default 8, register data width in bits.
REQ-002 Parameter D, default 3, register address width; 2**D registers.
REQ-003 Parameter RIM, default 2**D-1, register index written when an immediate write (write_imm) drains.
REQ-004 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, synchronous and active-low.
REQ-006 wb_valid  input  1  writeback request present.
REQ-007 wb_ready  output  1  queue can accept a request this cycle.
REQ-008 wb_addr  input  D  destination register; ignored when wb_imm=1.
REQ-009 wb_imm  input  1  request targets RIM.
REQ-010 wb_data  input  W  writeback value.
REQ-011 hold  input  1  suppress draining to the register file this cycle.
REQ-012 rf_write_en, rf_write_imm  output  1 each  register-file write strobes.
REQ-013 rf_waddr  output  D  register-file write address.
REQ-014 rf_data_in  output  W  register-file write data.
REQ-015 rd_addrA, rd_addrB  input  D each  operand read addresses from decode.
REQ-016 rf_raddrA, rf_raddrB  output  D each  register-file read addresses, equal to rd_addrA/rd_addrB combinationally.
REQ-017 rf_data_outA, rf_data_outB  input  W each  register-file read data.
REQ-018 rd_dataA, rd_dataB  output  W each  operand values returned to decode.
REQ-019 rd_hazard  output  1  an operand address matches a queued, undrained write.

Function
REQ-020 Two-entry in-order FIFO of {addr, imm, data}; occupancy count 0..2.
REQ-021 wb_ready=1 iff count<2; enqueue occurs on a cycle with wb_valid && wb_ready.
REQ-022 An entry stored with wb_imm=1 shall record RIM as its effective address.
REQ-023 Drain: when count>0 and hold=0, head entry drives the rf_* ports for exactly one cycle and is popped at that cycle's end.
REQ-024 Drain outputs are combinational from the head entry: rf_write_en=count>0 && !hold; rf_write_imm=head.imm && rf_write_en; rf_waddr=head addr; rf_data_in=head data.
REQ-025 When rf_write_en=0, rf_write_imm=0; rf_waddr and rf_data_in shall be 0.
REQ-026 Minimum latency: a request accepted in cycle N, with hold=0 in cycle N+1, is written to the register file in cycle N+1.
REQ-027 Simultaneous enqueue and drain: count unchanged; FIFO order preserved.
REQ-028 Enqueue is blocked when count=2, even if a drain occurs that cycle.
REQ-029 Operand match: an operand matches when its address equals the effective address of any valid queued entry; the youngest matching entry has priority.
REQ-030 No match: rd_dataX=rf_data_outX.

Reset
REQ-031 reset_n=0 at a rising edge: count=0 and entry contents cleared; this overrides any same-cycle enqueue or drain.
REQ-032 While reset_n=0: wb_ready=0 and rf_write_en=0; with count=0, rd_hazard=0 and rd_dataX=rf_data_outX.
REQ-033 A request or undrained entry present at reset is discarded.
REQ-034 No register-file write occurs in the first cycle after reset release.

Configuration
REQ-035 Macro WB_BYPASS_EN defined: operand match forwards youngest matching entry data to rd_dataX; rd_hazard=0 always.
REQ-036 WB_BYPASS_EN undefined: rd_dataX=rf_data_outX always; rd_hazard=1 on any operand match.

Verification
REQ-037 Reset, single request addr=3, data=0x5A, hold=0 -> next cycle rf_write_en=1, rf_waddr=3, rf_data_in=0x5A; count then returns to 0.
REQ-038 hold=1; enqueue addr=1 data=0x11, then addr=2 data=0x22 -> wb_ready=0 with count=2; release hold -> drains addr=1 then addr=2 on consecutive cycles.
REQ-039 Queue {addr=4 data=0x10, addr=4 data=0x20}, hold=1, rd_addrA=4 -> with WB_BYPASS_EN: rd_dataA=0x20, rd_hazard=0; without it: rd_hazard=1, rd_dataA=rf_data_outA.
REQ-040 wb_imm=1, wb_addr=2, data=0x7F -> rf_write_imm=1, rf_waddr=RIM (7 at D=3); rd_addrB=7 while queued forwards 0x7F when bypass is enabled.
REQ-041 count=1, enqueue and drain in the same cycle -> count stays 1; order and data correct.
REQ-042 count=2, reset_n=0 for one cycle with wb_valid=1 -> count=0, no rf_write_en pulse after release, wb_ready=1.
